imem_sync: RTL and testbench



---
 rtl/imem_sync.sv | 175 +++++++++++++++++
 tb/tb_imem_sync.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/imem_sync.sv
// imem_sync: synchronous, writable instruction memory with a req/ready/valid
// fetch handshake, WAIT_STATES extra cycles of latency, and a run-time loader
// write port. After reset the array is walked and zero-filled (MIPS nop)
// before the block reports ready.
//
// Optional build macro: IMEM_PARITY_EN
//   defined   - each word keeps an even-parity bit; parity_err_o flags a
//               mismatch on legal fetches (com_o is still delivered).
//   undefined - no parity storage; parity_err_o is constant 0.
module imem_sync #(
  parameter int unsigned DEPTH       = 64,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_i,
  input  logic [31:0] addr_i,
  output logic        ready_o,
  output logic        valid_o,
  output logic [31:0] com_o,
  output logic        fault_o,
  input  logic        ld_we_i,
  input  logic [31:0] ld_addr_i,
  input  logic [31:0] ld_data_i,
  output logic        ld_err_o,
  output logic        parity_err_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  localparam logic [1:0] S_CLEAR = 2'd0;
  localparam logic [1:0] S_IDLE  = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  localparam logic [2:0] WAIT_LAST = (WAIT_STATES == 0) ? 3'd0 : 3'(WAIT_STATES - 1);

  // A byte address is legal when word aligned and its word index is in range.
  function automatic logic addr_legal(input logic [31:0] a);
    return (a[1:0] == 2'b00) && (a[31:2] < 30'(DEPTH));
  endfunction

  logic [31:0]   mem_q [DEPTH];

  logic [1:0]    state_q,    state_d;
  logic [AW-1:0] clr_cnt_q,  clr_cnt_d;
  logic [2:0]    wait_cnt_q, wait_cnt_d;
  logic [AW-1:0] idx_q,      idx_d;
  logic          ok_q,       ok_d;
  logic          valid_q,    valid_d;
  logic [31:0]   com_q,      com_d;
  logic          fault_q,    fault_d;
  logic          ld_err_q,   ld_err_d;
  logic          perr_q,     perr_d;

  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [31:0]   mem_wdata;

`ifdef IMEM_PARITY_EN
  logic [DEPTH-1:0] par_q;
`endif

  // Next-state, array write port selection and response generation.
  always_comb begin
    state_d    = state_q;
    clr_cnt_d  = clr_cnt_q;
    wait_cnt_d = wait_cnt_q;
    idx_d      = idx_q;
    ok_d       = ok_q;
    valid_d    = 1'b0;
    com_d      = com_q;
    fault_d    = fault_q;
    ld_err_d   = 1'b0;
    perr_d     = 1'b0;
    mem_we     = 1'b0;
    mem_waddr  = clr_cnt_q;
    mem_wdata  = '0;

    case (state_q)
      S_CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = clr_cnt_q;
        mem_wdata = '0;
        clr_cnt_d = clr_cnt_q + 1'b1;
        // DEPTH is a power of two, so the last index is all ones.
        if (&clr_cnt_q) begin
          state_d = S_IDLE;
        end
      end
      S_IDLE: begin
        if (ld_we_i) begin
          if (addr_legal(ld_addr_i)) begin
            mem_we    = 1'b1;
            mem_waddr = ld_addr_i[AW+1:2];
            mem_wdata = ld_data_i;
          end else begin
            ld_err_d = 1'b1;
          end
        end else if (req_i) begin
          idx_d      = addr_i[AW+1:2];
          ok_d       = addr_legal(addr_i);
          wait_cnt_d = '0;
          state_d    = (WAIT_STATES == 0) ? S_RESP : S_WAIT;
        end
      end
      S_WAIT: begin
        if (wait_cnt_q == WAIT_LAST) begin
          state_d = S_RESP;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      default: begin
        valid_d = 1'b1;
        if (ok_q) begin
          com_d   = mem_q[idx_q];
          fault_d = 1'b0;
`ifdef IMEM_PARITY_EN
          perr_d  = (^mem_q[idx_q]) != par_q[idx_q];
`endif
        end else begin
          com_d   = '0;
          fault_d = 1'b1;
        end
        state_d = S_IDLE;
      end
    endcase
  end

  // Control and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_CLEAR;
      clr_cnt_q  <= '0;
      wait_cnt_q <= '0;
      idx_q      <= '0;
      ok_q       <= 1'b0;
      valid_q    <= 1'b0;
      com_q      <= '0;
      fault_q    <= 1'b0;
      ld_err_q   <= 1'b0;
      perr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_cnt_q  <= clr_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      idx_q      <= idx_d;
      ok_q       <= ok_d;
      valid_q    <= valid_d;
      com_q      <= com_d;
      fault_q    <= fault_d;
      ld_err_q   <= ld_err_d;
      perr_q     <= perr_d;
    end
  end

  // Storage array (not reset; the CLEAR walk rewrites it after every reset).
  always_ff @(posedge clk) begin
    if (rst_n && mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
`ifdef IMEM_PARITY_EN
      par_q[mem_waddr] <= ^mem_wdata;
`endif
    end
  end

  assign ready_o      = (state_q == S_IDLE);
  assign valid_o      = valid_q;
  assign com_o        = com_q;
  assign fault_o      = fault_q;
  assign ld_err_o     = ld_err_q;
  assign parity_err_o = perr_q;

endmodule

// File: tb/tb_imem_sync.sv
// Directed and randomized bench for imem_sync against an array-based model.
module tb_imem_sync;

  localparam int unsigned DEPTH = 64;
  localparam int unsigned WS    = 1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req;
  logic [31:0] addr;
  logic        ready, valid, fault, ld_err, parity_err;
  logic [31:0] com;
  logic        ld_we;
  logic [31:0] ld_addr, ld_data;

  always #5 clk = ~clk;

  imem_sync #(.DEPTH(DEPTH), .WAIT_STATES(WS)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_i        (req),
    .addr_i       (addr),
    .ready_o      (ready),
    .valid_o      (valid),
    .com_o        (com),
    .fault_o      (fault),
    .ld_we_i      (ld_we),
    .ld_addr_i    (ld_addr),
    .ld_data_i    (ld_data),
    .ld_err_o     (ld_err),
    .parity_err_o (parity_err)
  );

  int unsigned total  = 0;
  int unsigned passed = 0;
  logic [31:0] model [DEPTH];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic bit legal(input logic [31:0] a);
    return (a % 4 == 0) && ((a / 4) < DEPTH);
  endfunction

  function automatic logic [31:0] exp_com(input logic [31:0] a);
    return legal(a) ? model[a / 4] : 32'h0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!ready && n < 200) begin
      tick();
      n++;
    end
    chk({tag, "_ready"}, ready, 1);
  endtask

  task automatic do_load(input logic [31:0] a, input logic [31:0] d, input string tag);
    wait_ready(tag);
    ld_we = 1'b1; ld_addr = a; ld_data = d;
    tick();
    ld_we = 1'b0; ld_addr = $urandom; ld_data = $urandom;
    chk({tag, "_ld_err"}, ld_err, legal(a) ? 0 : 1);
    if (legal(a)) model[a / 4] = d;
  endtask

  task automatic do_fetch(input logic [31:0] a, input logic exp_perr, input string tag);
    logic [31:0] e;
    int n;
    e = exp_com(a);
    wait_ready(tag);
    req = 1'b1; addr = a;
    tick();
    req = 1'b0; addr = $urandom;
    n = 0;
    while (!valid && n < 50) begin
      tick();
      n++;
    end
    chk({tag, "_lat"}, n, WS + 1);
    chk({tag, "_com"}, com, e);
    chk({tag, "_fault"}, fault, legal(a) ? 0 : 1);
    chk({tag, "_perr"}, parity_err, exp_perr);
    tick();
    chk({tag, "_pulse"}, valid, 0);
    chk({tag, "_hold"}, com, e);
  endtask

  initial begin
    int n, vcnt;
    logic [31:0] a;
    req = 1'b0; addr = '0; ld_we = 1'b0; ld_addr = '0; ld_data = '0;
    for (int i = 0; i < DEPTH; i++) model[i] = 32'h0;

    // Reset state
    rst_n = 1'b0;
    tick(); tick();
    chk("rst_ready", ready, 0);
    chk("rst_valid", valid, 0);
    chk("rst_com", com, 0);
    chk("rst_fault", fault, 0);
    chk("rst_ld_err", ld_err, 0);
    chk("rst_perr", parity_err, 0);

    // Clear walk takes DEPTH edges
    rst_n = 1'b1;
    n = 0;
    while (!ready && n < 200) begin
      tick();
      n++;
    end
    chk("clear_edges", n, DEPTH);
    do_fetch(32'h0, 1'b0, "f0_after_clear");

    // Program load and fetch
    do_load(32'h0, 32'h20110003, "ld0");
    do_load(32'h4, 32'h22100001, "ld4");
    do_fetch(32'h4, 1'b0, "f4");
    do_fetch(32'h0, 1'b0, "f0");

    // Illegal addresses
    do_fetch(32'h2, 1'b0, "f_misalign");
    do_fetch(32'h100, 1'b0, "f_range");
    do_load(32'h101, 32'hDEADBEEF, "ld_bad");
    tick();
    chk("ld_err_pulse", ld_err, 0);
    do_fetch(32'h0, 1'b0, "f0_unchanged");
    do_load(32'hFC, 32'hCAFEF00D, "ld_top");
    do_fetch(32'hFC, 1'b0, "f_top");

    // Simultaneous load and request: load wins, held request accepted next
    wait_ready("sim");
    ld_we = 1'b1; ld_addr = 32'h8; ld_data = 32'h08000001;
    req = 1'b1; addr = 32'h8;
    tick();
    ld_we = 1'b0;
    model[2] = 32'h08000001;
    chk("sim_not_accepted", ready, 1);
    tick();
    req = 1'b0;
    n = 0;
    while (!valid && n < 50) begin
      tick();
      n++;
    end
    chk("sim_lat", n, WS + 1);
    chk("sim_com", com, 32'h08000001);
    chk("sim_fault", fault, 0);

    // Back-to-back fetches
    do_fetch(32'h8, 1'b0, "b2b_a");
    do_fetch(32'h4, 1'b0, "b2b_b");

    // Randomized loads and fetches
    for (int i = 0; i < 80; i++) begin
      case ($urandom_range(0, 9))
        7:       a = {$urandom_range(0, DEPTH - 1), 2'b00} | 32'($urandom_range(1, 3));
        8:       a = 32'(DEPTH * 4) + 32'($urandom_range(0, 1000) * 4);
        9:       a = $urandom;
        default: a = 32'($urandom_range(0, DEPTH - 1) * 4);
      endcase
      if ($urandom_range(0, 1) == 0) do_load(a, $urandom, "rnd_ld");
      else                           do_fetch(a, 1'b0, "rnd_f");
    end

    // Reset while a fetch is in WAIT
    wait_ready("rw");
    req = 1'b1; addr = 32'h4;
    tick();
    req = 1'b0;
    rst_n = 1'b0;
    tick();
    chk("rw_valid_rst", valid, 0);
    chk("rw_ready_rst", ready, 0);
    rst_n = 1'b1;
    for (int i = 0; i < DEPTH; i++) model[i] = 32'h0;
    n = 0; vcnt = 0;
    while (!ready && n < 200) begin
      tick();
      n++;
      if (valid) vcnt++;
    end
    chk("rw_no_valid", vcnt, 0);
    chk("rw_clear_edges", n, DEPTH);
    do_fetch(32'h4, 1'b0, "rw_f4");

`ifdef IMEM_PARITY_EN
    do_load(32'h0, 32'h0000000F, "par_ld");
    force dut.par_q[0] = 1'b1;
    do_fetch(32'h0, 1'b1, "par_f");
    release dut.par_q[0];
    do_load(32'h0, 32'h0000000F, "par_fix");
    do_fetch(32'h0, 1'b0, "par_ok");
`else
    do_load(32'h0, 32'h0000000F, "par_ld");
    do_fetch(32'h0, 1'b0, "par_off");
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
